// File: rtl/systolic_feeder_ctrl.sv
// rtl/systolic_feeder_ctrl.sv - NxN skewed operand sequencer and controller for an output-stationary systolic array
// Optional SYSTOLIC_FEEDER_CYCLE_COUNT_EN adds the o_cycles busy-cycle counter.

module systolic_feeder_ctrl #(
  parameter int W = 16,
  parameter int N = 3
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic             i_start,
  input  logic             i_mode,
  input  logic [W*N*N-1:0] i_A,
  input  logic [W*N*N-1:0] i_B,
  output logic [W*N-1:0]   o_a,
  output logic [W*N-1:0]   o_b,
  output logic             o_clr,
  output logic             o_mode,
  output logic             o_busy,
  output logic             o_done
`ifdef SYSTOLIC_FEEDER_CYCLE_COUNT_EN
  ,
  output logic [15:0]      o_cycles
`endif
);

  localparam int CW = $clog2(3*N);
  localparam logic [CW-1:0] T_LAST = CW'(3*N-3);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CLEAR,
    S_COMPUTE,
    S_DONE
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [CW-1:0]      t_cnt;
  logic [CW-1:0]      t_nxt;
  logic               accept;
  logic [W*N*N-1:0]   a_mat;
  logic [W*N*N-1:0]   b_mat;
  logic               mode_q;

  logic [W-1:0]       a_feed [N];
  logic [W-1:0]       b_feed [N];
  logic [W-1:0]       a_lane [N];
  logic [W-1:0]       b_lane [N];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state  <= S_IDLE;
      t_cnt  <= '0;
      a_mat  <= '0;
      b_mat  <= '0;
      mode_q <= 1'b0;
    end else if (i_en) begin
      state <= state_nxt;
      t_cnt <= t_nxt;
      if (accept) begin
        a_mat  <= i_A;
        b_mat  <= i_B;
        mode_q <= i_mode;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    t_nxt     = t_cnt;
    accept    = 1'b0;
    o_clr     = 1'b0;
    o_busy    = 1'b0;
    o_done    = 1'b0;
    case (state)
      S_IDLE: begin
        if (i_start) begin
          accept    = 1'b1;
          state_nxt = S_CLEAR;
        end
      end
      S_CLEAR: begin
        o_clr     = 1'b1;
        o_busy    = 1'b1;
        t_nxt     = '0;
        state_nxt = S_COMPUTE;
      end
      S_COMPUTE: begin
        o_busy = 1'b1;
        if (t_cnt == T_LAST) begin
          state_nxt = S_DONE;
        end else begin
          t_nxt = t_cnt + CW'(1);
        end
      end
      S_DONE: begin
        o_done = 1'b1;
        if (i_start) begin
          accept    = 1'b1;
          state_nxt = S_CLEAR;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign o_mode = mode_q;

  // Slice mux: column t of A feeds the rows, row t of B feeds the columns; zero once t runs past N.
  always_comb begin
    for (int k = 0; k < N; k++) begin
      a_feed[k] = '0;
      b_feed[k] = '0;
      if (int'(t_cnt) < N) begin
        a_feed[k] = a_mat[(k*N + int'(t_cnt))*W +: W];
        b_feed[k] = b_mat[(int'(t_cnt)*N + k)*W +: W];
      end
    end
  end

  for (genvar k = 0; k < N; k++) begin : g_lane
    if (k == 0) begin : g_direct
      assign a_lane[k] = a_feed[k];
      assign b_lane[k] = b_feed[k];
    end else begin : g_skew
      logic [W-1:0] a_sr [k];
      logic [W-1:0] b_sr [k];

      // Chains shift only while computing and are flushed otherwise so every op starts from zero bubbles.
      always_ff @(posedge i_clk) begin
        if (i_rst) begin
          for (int s = 0; s < k; s++) begin
            a_sr[s] <= '0;
            b_sr[s] <= '0;
          end
        end else if (i_en) begin
          if (state == S_COMPUTE) begin
            a_sr[0] <= a_feed[k];
            b_sr[0] <= b_feed[k];
            for (int s = 1; s < k; s++) begin
              a_sr[s] <= a_sr[s-1];
              b_sr[s] <= b_sr[s-1];
            end
          end else begin
            for (int s = 0; s < k; s++) begin
              a_sr[s] <= '0;
              b_sr[s] <= '0;
            end
          end
        end
      end

      assign a_lane[k] = a_sr[k-1];
      assign b_lane[k] = b_sr[k-1];
    end

    assign o_a[k*W +: W] = (state == S_COMPUTE) ? a_lane[k] : '0;
    assign o_b[k*W +: W] = (state == S_COMPUTE) ? b_lane[k] : '0;
  end

`ifdef SYSTOLIC_FEEDER_CYCLE_COUNT_EN
  logic [15:0] cyc_q;

  // Counts wall-clock busy cycles, so stalled cycles are included.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cyc_q <= '0;
    end else if (i_en && accept) begin
      cyc_q <= '0;
    end else if ((state == S_CLEAR || state == S_COMPUTE) && cyc_q != 16'hFFFF) begin
      cyc_q <= cyc_q + 16'd1;
    end
  end

  assign o_cycles = cyc_q;
`endif

endmodule

// File: tb/tb_systolic_feeder_ctrl.sv
// tb/tb_systolic_feeder_ctrl.sv - scoreboard bench for systolic_feeder_ctrl (N=3/W=16 and N=4/W=8 instances)

module tb_systolic_feeder_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1, en = 1'b1, mode = 1'b0, start3 = 1'b0, start4 = 1'b0;
  logic [143:0] A3 = '0, B3 = '0;
  logic [47:0]  oa3, ob3;
  logic         clr3, mode_o3, busy3, done3;
  logic [127:0] A4 = '0, B4 = '0;
  logic [31:0]  oa4, ob4;
  logic         clr4, mode_o4, busy4, done4;
`ifdef SYSTOLIC_FEEDER_CYCLE_COUNT_EN
  logic [15:0]  cyc3, cyc4;
`endif

  systolic_feeder_ctrl #(.W(16), .N(3)) u_dut3 (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_start(start3), .i_mode(mode),
    .i_A(A3), .i_B(B3), .o_a(oa3), .o_b(ob3), .o_clr(clr3), .o_mode(mode_o3),
    .o_busy(busy3), .o_done(done3)
`ifdef SYSTOLIC_FEEDER_CYCLE_COUNT_EN
    , .o_cycles(cyc3)
`endif
  );

  systolic_feeder_ctrl #(.W(8), .N(4)) u_dut4 (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_start(start4), .i_mode(mode),
    .i_A(A4), .i_B(B4), .o_a(oa4), .o_b(ob4), .o_clr(clr4), .o_mode(mode_o4),
    .o_busy(busy4), .o_done(done4)
`ifdef SYSTOLIC_FEEDER_CYCLE_COUNT_EN
    , .o_cycles(cyc4)
`endif
  );

  typedef struct packed { logic [47:0] a; logic [47:0] b; } v3_t;
  typedef struct packed { logic [31:0] a; logic [31:0] b; } v4_t;

  int errors = 0;
  int checks = 0;

  int ma3 [3][3], mb3 [3][3], ma4 [4][4], mb4 [4][4];
  v3_t q3 [$];
  v4_t q4 [$];
  logic [9*32-1:0]  cq3 [$];
  logic [16*32-1:0] cq4 [$];
  int sa3 [7][3], sb3 [7][3], sa4 [10][4], sb4 [10][4];
  int tidx3 = 0, tidx4 = 0;
  logic act3 = 1'b0, act4 = 1'b0, mode_exp3 = 1'b0, mode_exp4 = 1'b0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push3();
    v3_t v;
    logic [9*32-1:0] c;
    for (int t = 0; t < 7; t++) begin
      v = '0;
      for (int k = 0; k < 3; k++)
        if (t-k >= 0 && t-k < 3) begin
          v.a[k*16 +: 16] = 16'(ma3[k][t-k]);
          v.b[k*16 +: 16] = 16'(mb3[t-k][k]);
        end
      q3.push_back(v);
    end
    c = '0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) begin
        for (int k = 0; k < 3; k++)
          c[(i*3+j)*32 +: 32] = c[(i*3+j)*32 +: 32] + 32'(ma3[i][k] * mb3[k][j]);
        A3[(i*3+j)*16 +: 16] = 16'(ma3[i][j]);
        B3[(i*3+j)*16 +: 16] = 16'(mb3[i][j]);
      end
    cq3.push_back(c);
  endtask

  task automatic push4();
    v4_t v;
    logic [16*32-1:0] c;
    for (int t = 0; t < 10; t++) begin
      v = '0;
      for (int k = 0; k < 4; k++)
        if (t-k >= 0 && t-k < 4) begin
          v.a[k*8 +: 8] = 8'(ma4[k][t-k]);
          v.b[k*8 +: 8] = 8'(mb4[t-k][k]);
        end
      q4.push_back(v);
    end
    c = '0;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        for (int k = 0; k < 4; k++)
          c[(i*4+j)*32 +: 32] = c[(i*4+j)*32 +: 32] + 32'(ma4[i][k] * mb4[k][j]);
        A4[(i*4+j)*8 +: 8] = 8'(ma4[i][j]);
        B4[(i*4+j)*8 +: 8] = 8'(mb4[i][j]);
      end
    cq4.push_back(c);
  endtask

  // Reference array: each PE(i,j) multiplies row stream i delayed j with column stream j delayed i.
  task automatic monitor3();
    v3_t v;
    logic [9*32-1:0] got, exp;
    int s;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (clr3) begin
          tidx3 = 0;
          act3 = 1'b1;
        end else if (busy3) begin
          checks++;
          if (q3.size() == 0) begin
            errors++;
            $display("FAIL n3_unexpected_compute got busy=%b required empty scoreboard", busy3);
          end else begin
            if ({oa3, ob3} !== {q3[0].a, q3[0].b}) begin
              errors++;
              $display("FAIL n3_lanes t=%0d got a=%h b=%h required a=%h b=%h", tidx3, oa3, ob3, q3[0].a, q3[0].b);
            end
            checks++;
            if (mode_o3 !== mode_exp3) begin
              errors++;
              $display("FAIL n3_mode got %b required %b", mode_o3, mode_exp3);
            end
            if (en) begin
              if (tidx3 < 7)
                for (int i = 0; i < 3; i++) begin
                  sa3[tidx3][i] = int'(oa3[i*16 +: 16]);
                  sb3[tidx3][i] = int'(ob3[i*16 +: 16]);
                end
              v = q3.pop_front();
              tidx3++;
            end
          end
        end else if (done3 && act3) begin
          act3 = 1'b0;
          checks++;
          if (tidx3 != 7) begin
            errors++;
            $display("FAIL n3_compute_len got %0d required 7", tidx3);
          end
          got = '0;
          for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++) begin
              s = 0;
              for (int t = 0; t < 7; t++)
                if (t-j >= 0 && t-i >= 0) s += sa3[t-j][i] * sb3[t-i][j];
              got[(i*3+j)*32 +: 32] = 32'(s);
            end
          checks++;
          if (cq3.size() == 0) begin
            errors++;
            $display("FAIL n3_array_c got result required none pending");
          end else begin
            exp = cq3.pop_front();
            if (got !== exp) begin
              errors++;
              $display("FAIL n3_array_c got %h required %h", got, exp);
            end
          end
        end
      end
    end
  endtask

  task automatic monitor4();
    v4_t v;
    logic [16*32-1:0] got, exp;
    int s;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (clr4) begin
          tidx4 = 0;
          act4 = 1'b1;
        end else if (busy4) begin
          checks++;
          if (q4.size() == 0) begin
            errors++;
            $display("FAIL n4_unexpected_compute got busy=%b required empty scoreboard", busy4);
          end else begin
            if ({oa4, ob4} !== {q4[0].a, q4[0].b}) begin
              errors++;
              $display("FAIL n4_lanes t=%0d got a=%h b=%h required a=%h b=%h", tidx4, oa4, ob4, q4[0].a, q4[0].b);
            end
            checks++;
            if (mode_o4 !== mode_exp4) begin
              errors++;
              $display("FAIL n4_mode got %b required %b", mode_o4, mode_exp4);
            end
            if (en) begin
              if (tidx4 < 10)
                for (int i = 0; i < 4; i++) begin
                  sa4[tidx4][i] = int'(oa4[i*8 +: 8]);
                  sb4[tidx4][i] = int'(ob4[i*8 +: 8]);
                end
              v = q4.pop_front();
              tidx4++;
            end
          end
        end else if (done4 && act4) begin
          act4 = 1'b0;
          checks++;
          if (tidx4 != 10) begin
            errors++;
            $display("FAIL n4_compute_len got %0d required 10", tidx4);
          end
          got = '0;
          for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
              s = 0;
              for (int t = 0; t < 10; t++)
                if (t-j >= 0 && t-i >= 0) s += sa4[t-j][i] * sb4[t-i][j];
              got[(i*4+j)*32 +: 32] = 32'(s);
            end
          checks++;
          if (cq4.size() == 0) begin
            errors++;
            $display("FAIL n4_array_c got result required none pending");
          end else begin
            exp = cq4.pop_front();
            if (got !== exp) begin
              errors++;
              $display("FAIL n4_array_c got %h required %h", got, exp);
            end
          end
        end
      end
    end
  endtask

  task automatic run3(input int stall_n, input int stall_len, input logic md);
    int n, clr_cnt;
    mode = md;
    mode_exp3 = md;
    push3();
    start3 = 1'b1;
    step();
    start3 = 1'b0;
    n = 1;
    clr_cnt = clr3 ? 1 : 0;
    while (!done3 && n < 60) begin
      if (n == stall_n) begin
        en = 1'b0;
        repeat (stall_len) begin
          step();
          n++;
        end
        en = 1'b1;
      end
      step();
      n++;
      if (clr3) clr_cnt++;
    end
    checks++;
    if (n != 9 + stall_len) begin
      errors++;
      $display("FAIL n3_done_latency got %0d required %0d", n, 9 + stall_len);
    end
    checks++;
    if (clr_cnt != 1) begin
      errors++;
      $display("FAIL n3_clr_width got %0d required 1", clr_cnt);
    end
`ifdef SYSTOLIC_FEEDER_CYCLE_COUNT_EN
    checks++;
    if (cyc3 !== 16'(8 + stall_len)) begin
      errors++;
      $display("FAIL n3_cycles got %0d required %0d", cyc3, 8 + stall_len);
    end
`endif
    step();
    step();
    checks++;
    if ({done3, busy3, oa3, ob3} !== {1'b1, 1'b0, 96'd0}) begin
      errors++;
      $display("FAIL n3_done_hold got done=%b busy=%b a=%h b=%h required done=1 busy=0 lanes=0", done3, busy3, oa3, ob3);
    end
    checks++;
    if (q3.size() != 0 || cq3.size() != 0) begin
      errors++;
      $display("FAIL n3_scoreboard_drain got %0d/%0d required 0/0", q3.size(), cq3.size());
    end
  endtask

  task automatic run4(input logic md);
    int n;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        ma4[i][j] = int'($urandom_range(0, 255));
        mb4[i][j] = int'($urandom_range(0, 255));
      end
    mode = md;
    mode_exp4 = md;
    push4();
    start4 = 1'b1;
    step();
    start4 = 1'b0;
    n = 1;
    while (!done4 && n < 60) begin
      step();
      n++;
    end
    checks++;
    if (n != 12) begin
      errors++;
      $display("FAIL n4_done_latency got %0d required 12", n);
    end
    step();
    step();
    checks++;
    if (q4.size() != 0 || cq4.size() != 0) begin
      errors++;
      $display("FAIL n4_scoreboard_drain got %0d/%0d required 0/0", q4.size(), cq4.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    en = 1'b1;
    step();
    step();
    rst = 1'b0;
    checks++;
    if ({oa3, ob3, clr3, mode_o3, busy3, done3} !== '0) begin
      errors++;
      $display("FAIL reset_n3 got a=%h b=%h clr=%b mode=%b busy=%b done=%b required all 0", oa3, ob3, clr3, mode_o3, busy3, done3);
    end
    checks++;
    if ({oa4, ob4, clr4, mode_o4, busy4, done4} !== '0) begin
      errors++;
      $display("FAIL reset_n4 got a=%h b=%h clr=%b mode=%b busy=%b done=%b required all 0", oa4, ob4, clr4, mode_o4, busy4, done4);
    end
`ifdef SYSTOLIC_FEEDER_CYCLE_COUNT_EN
    checks++;
    if (cyc3 !== 16'd0) begin
      errors++;
      $display("FAIL reset_cycles got %0d required 0", cyc3);
    end
`endif
  endtask

  task automatic test_basic();
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) begin
        ma3[i][j] = i*3 + j + 1;
        mb3[i][j] = (i == j) ? 1 : 0;
      end
    run3(0, 0, 1'b0);
  endtask

  task automatic test_stall();
    run3(4, 3, 1'b0);
  endtask

  task automatic test_back_to_back();
    int n;
    mode = 1'b1;
    mode_exp3 = 1'b1;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) begin
        ma3[i][j] = i*3 + j + 11;
        mb3[i][j] = int'($urandom_range(0, 15));
      end
    push3();
    start3 = 1'b1;
    step();
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) begin
        ma3[i][j] = i*3 + j + 21;
        mb3[i][j] = int'($urandom_range(0, 15));
      end
    push3();
    n = 1;
    while (!done3 && n < 60) begin
      step();
      n++;
    end
    checks++;
    if (n != 9) begin
      errors++;
      $display("FAIL b2b_first_latency got %0d required 9", n);
    end
    step();
    checks++;
    if ({clr3, busy3, done3} !== 3'b110) begin
      errors++;
      $display("FAIL b2b_no_idle got clr=%b busy=%b done=%b required 1 1 0", clr3, busy3, done3);
    end
    start3 = 1'b0;
    n = 1;
    while (!done3 && n < 60) begin
      step();
      n++;
    end
    checks++;
    if (n != 9) begin
      errors++;
      $display("FAIL b2b_second_latency got %0d required 9", n);
    end
    step();
    step();
    checks++;
    if (q3.size() != 0 || cq3.size() != 0) begin
      errors++;
      $display("FAIL b2b_scoreboard_drain got %0d/%0d required 0/0", q3.size(), cq3.size());
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) begin
        ma3[i][j] = int'($urandom_range(1, 1000));
        mb3[i][j] = int'($urandom_range(1, 1000));
      end
    rst = 1'b1;
    step();
    rst = 1'b0;
    mode = 1'b1;
    mode_exp3 = 1'b1;
    push3();
    start3 = 1'b1;
    step();
    start3 = 1'b0;
    repeat (5) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    q3.delete();
    cq3.delete();
    act3 = 1'b0;
    checks++;
    if ({oa3, ob3, clr3, mode_o3, busy3, done3} !== '0) begin
      errors++;
      $display("FAIL reset_mid got a=%h b=%h clr=%b mode=%b busy=%b done=%b required all 0", oa3, ob3, clr3, mode_o3, busy3, done3);
    end
    step();
    checks++;
    if ({busy3, done3} !== 2'b00) begin
      errors++;
      $display("FAIL reset_mid_idle got busy=%b done=%b required 0 0", busy3, done3);
    end
    run3(0, 0, 1'b0);
  endtask

  task automatic test_n4();
    run4(1'b0);
    run4(1'b1);
  endtask

  initial begin
    fork
      monitor3();
      monitor4();
    join_none
    test_reset();
    test_basic();
    test_stall();
    test_back_to_back();
    test_reset_mid();
    test_n4();
`ifdef SYSTOLIC_FEEDER_CYCLE_COUNT_EN
    run3(4, 2, 1'b0);
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/systolic_feeder_ctrl.md
Name: systolic_feeder_ctrl

Overview:
- Parametrised NxN operand sequencer and controller for the output-stationary systolic array.
- Captures full A and B matrices on a start handshake and emits per-cycle skewed row/column operand vectors. Lane k is delayed k cycles.
- Pulses an accumulator clear, tracks compute length for any N, and raises done when the array results are valid.
- Generalises the fixed 3x3 controller with:
  - arbitrary N
  - start/busy/done handshake with restart
  - stall via i_en that freezes state instead of resetting it.

Parameters:
- W, 16, operand element width in bits.
- N, 3, array dimension (N >= 2). Derived counter width is CW = $clog2(3*N).

Ports:
- i_clk, input, 1, clock.
- i_rst, input, 1, synchronous active-high reset.
- i_en, input, 1, global enable. Low freezes all state and outputs.
- i_start, input, 1, request a new operation. Sampled only in IDLE or DONE.
- i_mode, input, 1, array mode. Captured at start.
- i_A, input, W*N*N, matrix A, row-major: A[r][c] at bits [(r*N+c)*W +: W].
- i_B, input, W*N*N, matrix B, row-major: B[r][c] at bits [(r*N+c)*W +: W].
- o_a, output, W*N, row lane i at [i*W +: W], feeds array row i.
- o_b, output, W*N, column lane j at [j*W +: W], feeds array column j.
- o_clr, output, 1, one-cycle accumulator clear to the array.
- o_mode, output, 1, captured mode, constant for the whole operation.
- o_busy, output, 1, high in CLEAR and COMPUTE.
- o_done, output, 1, high in DONE. Array o_C is valid while high.

Behaviour:
- Clock and reset:
  - Single clock i_clk.
  - i_rst is synchronous, active-high, and has priority over i_en.
- Reset values:
  - state IDLE, counter 0, operand registers 0, skew registers 0.
  - o_a=0, o_b=0, o_clr=0, o_mode=0, o_busy=0, o_done=0.
- States: IDLE, CLEAR, COMPUTE, DONE. All transitions require i_en=1.
- IDLE:
  - i_start=1 captures i_A, i_B and i_mode, then moves to CLEAR.
  - Otherwise stays in IDLE.
- CLEAR:
  - o_clr=1 and o_a=o_b=0 for exactly one cycle.
  - Then moves to COMPUTE with counter t=0.
- COMPUTE:
  - Lasts 3N-2 cycles, t = 0..3N-3.
  - Lane outputs:
    - o_a lane i = A[i][t-i] when 0 <= t-i < N, else 0.
    - o_b lane j = B[t-j][j] when 0 <= t-j < N, else 0.
  - Implementation: lane k uses a k-deep delay register chain fed from a slice mux indexed by t (zero when t >= N). Lane 0 has no delay.
  - At t=3N-3, moves to DONE.
- DONE:
  - o_done=1 and o_a=o_b=0.
  - i_start=1 recaptures operands and goes to CLEAR in the next cycle (back-to-back restart).
  - Otherwise holds DONE indefinitely.
- i_start while busy: ignored. Captured operands do not change mid-operation.
- i_en=0:
  - State, counter, operand, skew and all output registers hold, including o_clr. o_clr can therefore be high for more than one cycle only through a stall.
  - i_start is ignored.
  - The array must be stalled by the same i_en.
- Reset mid-operation: returns to IDLE next cycle with all outputs at their reset values. No done pulse.
- Latency:
  - start edge -> CLEAR at +1 cycle -> COMPUTE at +2 -> DONE at +3N cycles (N=3: 9 cycles).
  - Each stalled cycle adds one.
- Arithmetic: none on operands. Values pass through unmodified; zero padding in bubble slots.

Optional Feature:
- Macro: SYSTOLIC_FEEDER_CYCLE_COUNT_EN.
- With it:
  - Adds output o_cycles, 16 bits.
  - Cleared when an operation is accepted; increments on every cycle the block is in CLEAR or COMPUTE, including stalled cycles.
  - Holds in DONE, saturates at 16'hFFFF, and is 0 after reset.
- Without it: the port and the counter do not exist.

Test Plan:
- N=3, W=16, A=[1..9], B=identity, i_start pulse, i_en=1:
  - o_clr high exactly one cycle.
  - o_a lane0 = 1,2,3,0,0,0,0.
  - o_a lane1 = 0,4,5,6,0,0,0.
  - o_a lane2 = 0,0,7,8,9,0,0.
  - o_done rises 9 cycles after the start edge.
  - Array o_C = A.
- Same stimulus with i_en=0 for 3 cycles mid-COMPUTE (t=2):
  - All outputs frozen during the stall.
  - Lane sequences are identical minus the stall gap.
  - o_done rises at 12 cycles.
- i_start held high through the whole operation:
  - Operands recaptured only in DONE.
  - Second op's CLEAR directly follows DONE, with no IDLE cycle.
  - New A/B values appear only from the second COMPUTE.
- i_rst asserted at COMPUTE t=4:
  - Next cycle IDLE, o_a=o_b=0, o_busy=0, o_done=0.
  - A subsequent start completes normally.
- N=4, W=8, random A/B:
  - COMPUTE lasts 10 cycles.
  - Scoreboard checks the per-lane skew formula and the array o_C against a reference product, with mode 0 and mode 1 each checked once.
- Optional feature enabled, N=3, two-cycle stall: o_cycles=10 at DONE (1 CLEAR + 7 COMPUTE + 2 stall).
